dpll_loop_ctrl: RTL

//  Parametrised digital loop core for the next-gen DPLL: phase detector, PI loop filter
//  and hysteretic lock detector in one clock domain. Consumes 1-cycle ref/fb edge

---
 rtl/dpll_loop_ctrl_pkg.sv | 33 +++
 rtl/dpll_loop_ctrl_if.sv | 22 ++
 rtl/dpll_loop_ctrl_phase_det.sv | 107 ++++++++++
 rtl/dpll_loop_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dpll_loop_ctrl_pkg.sv
// Shared types and arithmetic helpers for the DPLL loop core.
package dpll_loop_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LEAD_REF = 2'd1,
      LEAD_FB  = 2'd2
   } pfd_state_t;

   function automatic int calc_err_max(input int err_w);
      calc_err_max = (2 ** (err_w - 1)) - 1;
   endfunction

   function automatic int calc_acc_w(input int ctrl_w, input int ki_shift);
      calc_acc_w = ctrl_w + ki_shift;
   endfunction

   // Clamp a wide signed value into the range of a w-bit signed word.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         sat_signed = hi;
      end else if (v < lo) begin
         sat_signed = lo;
      end else begin
         sat_signed = v;
      end
   endfunction

endpackage

// File: rtl/dpll_loop_ctrl_if.sv
// Strobe inputs and DCO/status outputs of the DPLL loop core.
interface dpll_loop_ctrl_if #(parameter int CTRL_W = 16);
   logic                     ref_pulse;
   logic                     fb_pulse;
   logic                     freeze;
   logic signed [CTRL_W-1:0] ctrl;
   logic                     ctrl_valid;
   logic                     up;
   logic                     down;
   logic                     locked;
   logic                     holdover;

   modport master (
      output ref_pulse, fb_pulse, freeze,
      input  ctrl, ctrl_valid, up, down, locked, holdover
   );

   modport slave (
      input  ref_pulse, fb_pulse, freeze,
      output ctrl, ctrl_valid, up, down, locked, holdover
   );
endinterface

// File: rtl/dpll_loop_ctrl_phase_det.sv
// Counting phase detector: measures ref/fb edge separation in clock cycles.
module dpll_phase_det
   import dpll_loop_ctrl_pkg::*;
#(
   parameter int ERR_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ref_pulse,
   input  logic                    fb_pulse,
   input  logic                    force_idle,
   output logic signed [ERR_W-1:0] err,
   output logic                    err_valid,
   output logic                    slip,
   output logic                    up,
   output logic                    down
);

   localparam logic [ERR_W-2:0] CNT_MAX = (ERR_W-1)'(calc_err_max(ERR_W));
   localparam logic [ERR_W-2:0] CNT_ONE = {{(ERR_W-2){1'b0}}, 1'b1};
   localparam logic [ERR_W-2:0] CNT_ZERO = {(ERR_W-1){1'b0}};
   localparam logic signed [ERR_W-1:0] ERR_MAX_S = $signed({1'b0, CNT_MAX});
   localparam logic signed [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

   pfd_state_t              state, state_n;
   logic [ERR_W-2:0]        cnt, cnt_n, cnt_inc;
   logic signed [ERR_W-1:0] err_n, err_pos;
   logic                    err_valid_n, slip_n;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      err_n       = ERR_ZERO;
      err_valid_n = 1'b0;
      slip_n      = 1'b0;
      err_pos     = $signed({1'b0, cnt});
      cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      if (force_idle) begin
         state_n = IDLE;
         cnt_n   = CNT_ZERO;
      end else begin
         case (state)
            IDLE: begin
               if (ref_pulse && fb_pulse) begin
                  err_valid_n = 1'b1;
               end else if (ref_pulse) begin
                  state_n = LEAD_REF;
                  cnt_n   = CNT_ONE;
               end else if (fb_pulse) begin
                  state_n = LEAD_FB;
                  cnt_n   = CNT_ONE;
               end else begin
                  cnt_n = CNT_ZERO;
               end
            end
            LEAD_REF: begin
               if (ref_pulse && fb_pulse) begin
                  err_n = err_pos; err_valid_n = 1'b1; cnt_n = CNT_ONE;
               end else if (fb_pulse) begin
                  err_n = err_pos; err_valid_n = 1'b1; state_n = IDLE; cnt_n = CNT_ZERO;
               end else if (ref_pulse) begin
                  // A second ref before any fb means a whole cycle was lost.
                  err_n = ERR_MAX_S; err_valid_n = 1'b1; slip_n = 1'b1; cnt_n = CNT_ONE;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            LEAD_FB: begin
               if (ref_pulse && fb_pulse) begin
                  err_n = -err_pos; err_valid_n = 1'b1; cnt_n = CNT_ONE;
               end else if (ref_pulse) begin
                  err_n = -err_pos; err_valid_n = 1'b1; state_n = IDLE; cnt_n = CNT_ZERO;
               end else if (fb_pulse) begin
                  err_n = -ERR_MAX_S; err_valid_n = 1'b1; slip_n = 1'b1; cnt_n = CNT_ONE;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = CNT_ZERO;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= CNT_ZERO;
         err       <= ERR_ZERO;
         err_valid <= 1'b0;
         slip      <= 1'b0;
         up        <= 1'b0;
         down      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         err       <= err_n;
         err_valid <= err_valid_n;
         slip      <= slip_n;
         up        <= (state_n == LEAD_REF);
         down      <= (state_n == LEAD_FB);
      end
   end

endmodule

// File: rtl/dpll_loop_ctrl.sv
// DPLL loop core: phase detector, PI loop filter and hysteretic lock detector.
// Optional reference-loss watchdog enabled by defining DPLL_HOLDOVER_EN.
module dpll_loop_ctrl
   import dpll_loop_ctrl_pkg::*;
#(
   parameter int CTRL_W       = 16,
   parameter int ERR_W        = 8,
   parameter int KP_SHIFT     = 2,
   parameter int KI_SHIFT     = 6,
   parameter int CTRL_INIT    = 0,
   parameter int LOCK_TOL     = 1,
   parameter int UNLOCK_TOL   = 4,
   parameter int LOCK_CNT     = 16,
   parameter int HOLD_TIMEOUT = 1024
) (
   input logic            clk,
   input logic            rst,
   dpll_loop_ctrl_if.slave bus
);

   localparam int ACC_W  = calc_acc_w(CTRL_W, KI_SHIFT);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam logic signed [ACC_W-1:0]  INTEG_INIT = ACC_W'(CTRL_INIT) <<< KI_SHIFT;
   localparam logic signed [CTRL_W-1:0] CTRL_RST   = CTRL_W'(CTRL_INIT);
   localparam logic [ERR_W-1:0]  LOCK_TOL_V   = ERR_W'(LOCK_TOL);
   localparam logic [ERR_W-1:0]  UNLOCK_TOL_V = ERR_W'(UNLOCK_TOL);
   localparam logic [GOOD_W-1:0] LOCK_CNT_V   = GOOD_W'(LOCK_CNT);

   logic signed [ERR_W-1:0]  err;
   logic                     err_valid, slip, pd_up, pd_down;
   logic                     hold_set, holdover_q, force_idle, frozen;
   logic signed [ACC_W-1:0]  integ, integ_new;
   logic signed [CTRL_W-1:0] ctrl_q, ctrl_new;
   logic signed [63:0]       acc_sum, ctrl_sum;
   logic                     ctrl_valid_q, locked_q;
   logic [ERR_W-1:0]         err_mag;
   logic [GOOD_W-1:0]        good_cnt, good_inc;

   dpll_phase_det #(.ERR_W(ERR_W)) u_pd (
      .clk        (clk),
      .rst        (rst),
      .ref_pulse  (bus.ref_pulse),
      .fb_pulse   (bus.fb_pulse),
      .force_idle (force_idle),
      .err        (err),
      .err_valid  (err_valid),
      .slip       (slip),
      .up         (pd_up),
      .down       (pd_down)
   );

`ifdef DPLL_HOLDOVER_EN
   localparam int WD_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(HOLD_TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_TOP  = WD_W'(HOLD_TIMEOUT);
   logic [WD_W-1:0] wd_cnt;

   // A ref arriving during holdover clears it and is taken by the PD as an IDLE arrival.
   always_comb begin
      hold_set   = !bus.ref_pulse && (wd_cnt == WD_LAST);
      force_idle = hold_set || (holdover_q && !bus.ref_pulse);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt     <= {WD_W{1'b0}};
         holdover_q <= 1'b0;
      end else if (bus.ref_pulse) begin
         wd_cnt     <= {WD_W{1'b0}};
         holdover_q <= 1'b0;
      end else begin
         if (wd_cnt != WD_TOP) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (hold_set) begin
            holdover_q <= 1'b1;
         end
      end
   end
`else
   always_comb begin
      hold_set   = 1'b0;
      force_idle = 1'b0;
      holdover_q = 1'b0;
   end
`endif

   always_comb begin
      frozen    = bus.freeze || holdover_q || hold_set;
      acc_sum   = 64'(integ) + 64'(err);
      integ_new = ACC_W'(sat_signed(acc_sum, ACC_W));
      ctrl_sum  = 64'(integ_new >>> KI_SHIFT) + (64'(err) <<< KP_SHIFT);
      ctrl_new  = CTRL_W'(sat_signed(ctrl_sum, CTRL_W));
      err_mag   = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
      good_inc  = (good_cnt == LOCK_CNT_V) ? good_cnt : good_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         integ        <= INTEG_INIT;
         ctrl_q       <= CTRL_RST;
         ctrl_valid_q <= 1'b0;
      end else if (err_valid && !frozen) begin
         integ        <= integ_new;
         ctrl_q       <= ctrl_new;
         ctrl_valid_q <= 1'b1;
      end else begin
         ctrl_valid_q <= 1'b0;
      end
   end

   // Hysteresis: moderate error only restarts the count, large error or slip drops lock.
   always_ff @(posedge clk) begin
      if (rst || hold_set) begin
         good_cnt <= {GOOD_W{1'b0}};
         locked_q <= 1'b0;
      end else if (err_valid) begin
         if (slip || (err_mag > UNLOCK_TOL_V)) begin
            good_cnt <= {GOOD_W{1'b0}};
            locked_q <= 1'b0;
         end else if (err_mag > LOCK_TOL_V) begin
            good_cnt <= {GOOD_W{1'b0}};
         end else begin
            good_cnt <= good_inc;
            if (good_inc == LOCK_CNT_V) begin
               locked_q <= 1'b1;
            end
         end
      end
   end

   assign bus.ctrl       = ctrl_q;
   assign bus.ctrl_valid = ctrl_valid_q;
   assign bus.up         = pd_up;
   assign bus.down       = pd_down;
   assign bus.locked     = locked_q;
   assign bus.holdover   = holdover_q;

endmodule
